// File: rtl/hub75_bcm_scanner_if.sv
// Frame-buffer read port and HUB75 panel pins of the BCM scanner.
interface hub75_bcm_scanner_if #(
    parameter int unsigned MATRIX_WIDTH  = 64,
    parameter int unsigned MATRIX_HEIGHT = 64,
    parameter int unsigned BIT_DEPTH     = 6
);
    localparam int unsigned SCAN = MATRIX_HEIGHT / 2;
    localparam int unsigned AW   = $clog2(MATRIX_WIDTH * SCAN);
    localparam int unsigned RW   = $clog2(SCAN);

    logic [AW-1:0]          r_addr;
    logic [3*BIT_DEPTH-1:0] rgb_0;
    logic [3*BIT_DEPTH-1:0] rgb_1;
    logic [1:0]             r;
    logic [1:0]             g;
    logic [1:0]             b;
    logic [RW-1:0]          addr;
    logic                   led_clk;
    logic                   latch;
    logic                   oe_n;

    modport master (
        output r_addr, r, g, b, addr, led_clk, latch, oe_n,
        input  rgb_0, rgb_1
    );

    modport slave (
        input  r_addr, r, g, b, addr, led_clk, latch, oe_n,
        output rgb_0, rgb_1
    );
endinterface

// File: rtl/hub75_bcm_scanner.sv
// HUB75 scanner: per row and bit plane, shift a plane out, latch it, then
// light it for BASE_TICKS<<plane cycles scaled by the global brightness.
module hub75_bcm_scanner #(
    parameter int unsigned MATRIX_WIDTH  = 64,
    parameter int unsigned MATRIX_HEIGHT = 64,
    parameter int unsigned BIT_DEPTH     = 6,
    parameter int unsigned BASE_TICKS    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    input  logic                       stop,
    input  logic [7:0]                 brightness,
    hub75_bcm_scanner_if.master        bus,
    output logic                       busy,
    output logic                       frame_done
);
    localparam int unsigned SCAN = MATRIX_HEIGHT / 2;
    localparam int unsigned RW   = $clog2(SCAN);
    localparam int unsigned CLW  = $clog2(MATRIX_WIDTH);
    localparam int unsigned AW   = RW + CLW;
    localparam int unsigned DMAX = BASE_TICKS << (BIT_DEPTH - 1);
    localparam int unsigned CW   = $clog2(DMAX) + 1;
    localparam int unsigned PW   = (BIT_DEPTH > 1) ? $clog2(BIT_DEPTH) : 1;
    localparam int unsigned MW   = CW + 9;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREFETCH = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_LATCH    = 3'd3;
    localparam logic [2:0] S_DISPLAY  = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [AW-1:0]  r_addr_q, r_addr_d;
    logic [1:0]     r_q, r_d, g_q, g_d, b_q, b_d;
    logic [RW-1:0]  addr_q, addr_d;
    logic           led_clk_q, led_clk_d;
    logic           latch_q, latch_d;
    logic           oe_n_q, oe_n_d;
    logic           busy_q, busy_d;
    logic           frame_done_q, frame_done_d;
    logic           stop_q, stop_d;
    logic [RW-1:0]  row_q, row_d;
    logic [PW-1:0]  plane_q, plane_d;
    logic [CLW-1:0] col_q, col_d;
    logic           phase_q, phase_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  on_q, on_d;

    logic [CW-1:0]        dur;
    logic [MW-1:0]        on_prod;
    logic [CW-1:0]        on_new;
    logic [BIT_DEPTH-1:0] r0, g0, b0, r1, g1, b1;

    // Plane duration and lit time, full-width product before the >>8
    assign dur     = CW'(BASE_TICKS << plane_q);
    assign on_prod = MW'(dur) * (MW'(brightness) + MW'(1));
    assign on_new  = CW'(on_prod >> 8);

    assign r0 = bus.rgb_0[3*BIT_DEPTH-1 -: BIT_DEPTH];
    assign g0 = bus.rgb_0[2*BIT_DEPTH-1 -: BIT_DEPTH];
    assign b0 = bus.rgb_0[BIT_DEPTH-1:0];
    assign r1 = bus.rgb_1[3*BIT_DEPTH-1 -: BIT_DEPTH];
    assign g1 = bus.rgb_1[2*BIT_DEPTH-1 -: BIT_DEPTH];
    assign b1 = bus.rgb_1[BIT_DEPTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            r_addr_q     <= '0;
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            addr_q       <= '0;
            led_clk_q    <= 1'b0;
            latch_q      <= 1'b0;
            oe_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            stop_q       <= 1'b0;
            row_q        <= '0;
            plane_q      <= '0;
            col_q        <= '0;
            phase_q      <= 1'b0;
            cnt_q        <= '0;
            on_q         <= '0;
        end else begin
            state_q      <= state_d;
            r_addr_q     <= r_addr_d;
            r_q          <= r_d;
            g_q          <= g_d;
            b_q          <= b_d;
            addr_q       <= addr_d;
            led_clk_q    <= led_clk_d;
            latch_q      <= latch_d;
            oe_n_q       <= oe_n_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            stop_q       <= stop_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            on_q         <= on_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        r_addr_d     = r_addr_q;
        r_d          = r_q;
        g_d          = g_q;
        b_d          = b_q;
        addr_d       = addr_q;
        led_clk_d    = led_clk_q;
        latch_d      = 1'b0;
        oe_n_d       = oe_n_q;
        frame_done_d = 1'b0;
        stop_d       = stop_q;
        row_d        = row_q;
        plane_d      = plane_q;
        col_d        = col_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        on_d         = on_q;

        if (stop && ((state_q != S_IDLE) || go)) begin
            stop_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                oe_n_d    = 1'b1;
                led_clk_d = 1'b0;
                if (go) begin
                    r_addr_d = '0;
                    row_d    = '0;
                    plane_d  = '0;
                    state_d  = S_PREFETCH;
                end
            end
            S_PREFETCH: begin
                col_d   = '0;
                phase_d = 1'b0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                // Phase 0 presents data and drops led_clk; phase 1 raises it
                if (!phase_q) begin
                    r_d       = {r1[plane_q], r0[plane_q]};
                    g_d       = {g1[plane_q], g0[plane_q]};
                    b_d       = {b1[plane_q], b0[plane_q]};
                    led_clk_d = 1'b0;
                    r_addr_d  = r_addr_q + AW'(1);
                    phase_d   = 1'b1;
                end else begin
                    led_clk_d = 1'b1;
                    phase_d   = 1'b0;
                    if (col_q == CLW'(MATRIX_WIDTH - 1)) begin
                        col_d   = '0;
                        latch_d = 1'b1;
                        addr_d  = row_q;
                        state_d = S_LATCH;
                    end else begin
                        col_d = col_q + CLW'(1);
                    end
                end
            end
            S_LATCH: begin
                led_clk_d = 1'b0;
                on_d      = on_new;
                oe_n_d    = (on_new == '0);
                cnt_d     = '0;
                state_d   = S_DISPLAY;
            end
            S_DISPLAY: begin
                if (cnt_q == dur - CW'(1)) begin
                    oe_n_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_PREFETCH;
                    if (plane_q != PW'(BIT_DEPTH - 1)) begin
                        plane_d = plane_q + PW'(1);
                    end else begin
                        plane_d = '0;
                        if (row_q != RW'(SCAN - 1)) begin
                            row_d = row_q + RW'(1);
                        end else begin
                            row_d        = '0;
                            frame_done_d = 1'b1;
                            if (stop_q) begin
                                stop_d  = 1'b0;
                                state_d = S_IDLE;
                            end
                        end
                    end
                    r_addr_d = {row_d, CLW'(0)};
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    oe_n_d = !((cnt_q + CW'(1)) < on_q);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.r_addr  = r_addr_q;
    assign bus.r       = r_q;
    assign bus.g       = g_q;
    assign bus.b       = b_q;
    assign bus.addr    = addr_q;
    assign bus.led_clk = led_clk_q;
    assign bus.latch   = latch_q;
    assign bus.oe_n    = oe_n_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Bench for hub75_bcm_scanner: walks whole frames cycle by cycle against
// timing and pixel data derived from the plane/row scan rules.
module tb_hub75_bcm_scanner;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int BD   = 2;
    localparam int BT   = 2;
    localparam int SCAN = H / 2;
    localparam int N    = W * SCAN;

    typedef logic [3*BD-1:0] pix_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic       stop;
    logic [7:0] brightness;
    logic       busy;
    logic       frame_done;

    hub75_bcm_scanner_if #(.MATRIX_WIDTH(W), .MATRIX_HEIGHT(H), .BIT_DEPTH(BD)) bus ();

    hub75_bcm_scanner #(
        .MATRIX_WIDTH(W), .MATRIX_HEIGHT(H), .BIT_DEPTH(BD), .BASE_TICKS(BT)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .stop(stop), .brightness(brightness),
        .bus(bus), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    pix_t mem0 [N];
    pix_t mem1 [N];

    // Synchronous RAM with one cycle of read latency
    always @(posedge clk) begin
        bus.rgb_0 <= mem0[bus.r_addr];
        bus.rgb_1 <= mem1[bus.r_addr];
    end

    int n_cmp = 0;
    int n_err = 0;
    bit fd_exp = 1'b0;
    int cur_row = 0;
    int cur_plane = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s row=%0d plane=%0d: observed %0d expected %0d",
                   tag, cur_row, cur_plane, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        go   = 1'b0;
        stop = 1'b0;
    endtask

    function automatic int bitpair(input int ch, input int a, input int p);
        pix_t x0;
        pix_t x1;
        x0 = mem0[a];
        x1 = mem1[a];
        return (int'(x1[ch*BD+p]) << 1) | int'(x0[ch*BD+p]);
    endfunction

    task automatic chk_reset();
        chk("rst_raddr", int'(bus.r_addr), 0);
        chk("rst_rgb", int'({bus.r, bus.g, bus.b}), 0);
        chk("rst_addr", int'(bus.addr), 0);
        chk("rst_ledclk", int'(bus.led_clk), 0);
        chk("rst_latch", int'(bus.latch), 0);
        chk("rst_oe_n", int'(bus.oe_n), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_fdone", int'(frame_done), 0);
    endtask

    task automatic expect_idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("idle_fdone", int'(frame_done), int'(fd_exp));
            fd_exp = 1'b0;
            chk("idle_busy", int'(busy), 0);
            chk("idle_oe_n", int'(bus.oe_n), 1);
            chk("idle_latch", int'(bus.latch), 0);
            chk("idle_ledclk", int'(bus.led_clk), 0);
        end
    endtask

    // One frame: prefetch, 2W shift cycles, latch, D_p display cycles per plane
    task automatic walk_frame(input int bv, input bit stop_mid);
        for (int row = 0; row < SCAN; row++) begin
            for (int p = 0; p < BD; p++) begin
                int d;
                int on;
                cur_row   = row;
                cur_plane = p;
                d  = BT << p;
                on = (d * (bv + 1)) >> 8;
                tick();
                chk("pf_fdone", int'(frame_done), int'(fd_exp));
                fd_exp = 1'b0;
                chk("pf_busy", int'(busy), 1);
                chk("pf_raddr", int'(bus.r_addr), row * W);
                chk("pf_oe_n", int'(bus.oe_n), 1);
                tick();
                chk("sh0_ledclk", int'(bus.led_clk), 0);
                chk("sh0_oe_n", int'(bus.oe_n), 1);
                for (int c = 0; c < W; c++) begin
                    int a;
                    a = row * W + c;
                    tick();
                    chk("a_ledclk", int'(bus.led_clk), 0);
                    chk("a_r", int'(bus.r), bitpair(2, a, p));
                    chk("a_g", int'(bus.g), bitpair(1, a, p));
                    chk("a_b", int'(bus.b), bitpair(0, a, p));
                    chk("a_raddr", int'(bus.r_addr), (a + 1) % N);
                    chk("a_latch", int'(bus.latch), 0);
                    chk("a_oe_n", int'(bus.oe_n), 1);
                    if (stop_mid && row == 0 && p == 0 && c == 1) stop = 1'b1;
                    tick();
                    chk("b_ledclk", int'(bus.led_clk), 1);
                    chk("b_r", int'(bus.r), bitpair(2, a, p));
                    chk("b_b", int'(bus.b), bitpair(0, a, p));
                    chk("b_latch", int'(bus.latch), int'(c == W - 1));
                    chk("b_oe_n", int'(bus.oe_n), 1);
                    if (c == W - 1) chk("lat_addr", int'(bus.addr), row);
                end
                for (int k = 0; k < d; k++) begin
                    tick();
                    chk("disp_oe_n", int'(bus.oe_n), (k < on) ? 0 : 1);
                    chk("disp_latch", int'(bus.latch), 0);
                    chk("disp_ledclk", int'(bus.led_clk), 0);
                    chk("disp_fdone", int'(frame_done), 0);
                    chk("disp_addr", int'(bus.addr), row);
                end
                if (row == SCAN - 1 && p == BD - 1) fd_exp = 1'b1;
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            mem0[i] = pix_t'($urandom);
            mem1[i] = pix_t'($urandom);
        end
    endtask

    task automatic fill_red_full();
        for (int i = 0; i < N; i++) begin
            mem0[i] = pix_t'($urandom) | pix_t'(3 << (2 * BD));
            mem1[i] = pix_t'($urandom) | pix_t'(3 << (2 * BD));
        end
    endtask

    task automatic fill_col2();
        for (int i = 0; i < N; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        for (int rw = 0; rw < SCAN; rw++) mem0[rw * W + 2] = pix_t'(2 << (2 * BD));
    endtask

    task automatic one_frame(input int bv);
        brightness = 8'(bv);
        go   = 1'b1;
        stop = 1'b1;
        walk_frame(bv, 1'b0);
        expect_idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bv;
        rst        = 1'b1;
        go         = 1'b0;
        stop       = 1'b0;
        brightness = 8'd255;
        fill_red_full();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_reset();
        expect_idle(3);

        // Continuous scanning, then stop mid row 0 of the second frame
        brightness = 8'd255;
        go = 1'b1;
        walk_frame(255, 1'b0);
        walk_frame(255, 1'b1);
        expect_idle(3);

        fill_red_full();
        one_frame(127);

        fill_random();
        one_frame(0);

        fill_col2();
        one_frame(255);

        for (int i = 0; i < 4; i++) begin
            fill_random();
            bv = int'($urandom_range(0, 255));
            one_frame(bv);
        end

        // Reset in the middle of SHIFT, then restart cleanly
        for (int i = 0; i < N; i++) begin
            mem0[i] = '1;
            mem1[i] = '1;
        end
        brightness = 8'd200;
        go = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_r", int'(bus.r), 3);
        chk("pre_rst_addr", int'(bus.addr), SCAN - 1);
        rst = 1'b1;
        tick();
        chk_reset();
        rst = 1'b0;
        fd_exp = 1'b0;
        expect_idle(2);
        fill_random();
        go = 1'b1;
        walk_frame(200, 1'b1);
        expect_idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
